// File: rtl/pulses_pkg.sv
// Address map and helpers shared by pulse_seq_multi and pulse_window_ch.
// PULSES_CPMG_EN adds per-channel repeat registers after the slot block.
package pulses_pkg;

  typedef enum logic {FLD_START = 1'b0, FLD_STOP = 1'b1} field_e;

  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_NUM_PULSE  = 4;
  localparam int unsigned ADDR_PERIOD    = 0;
  localparam int unsigned ADDR_SYNC      = 1;
  localparam int unsigned ADDR_SLOT_BASE = 2;
  localparam int unsigned ADDR_REP_BASE  = ADDR_SLOT_BASE + 2 * DEF_NUM_CH * DEF_NUM_PULSE;

  function automatic int unsigned addr_slot(int unsigned ch, int unsigned p, field_e fld,
                                            int unsigned num_pulse);
    return ADDR_SLOT_BASE + 2 * (ch * num_pulse + p) + 32'(fld);
  endfunction

  // sel=0: rep_count, sel=1: rep_interval
  function automatic int unsigned addr_rep(int unsigned ch, logic sel, int unsigned num_ch,
                                           int unsigned num_pulse);
    return ADDR_SLOT_BASE + 2 * num_ch * num_pulse + 2 * ch + 32'(sel);
  endfunction

  // Address space always reserves the repeat registers so the map is build-independent
  function automatic int unsigned num_regs(int unsigned num_ch, int unsigned num_pulse);
    return ADDR_SLOT_BASE + 2 * num_ch * num_pulse + 2 * num_ch;
  endfunction

  function automatic int unsigned addr_width(int unsigned num_ch, int unsigned num_pulse);
    return $clog2(num_regs(num_ch, num_pulse));
  endfunction

endpackage

// File: rtl/pulse_window_ch.sv
// One channel's start/stop window comparators; with PULSES_CPMG_EN the last
// enabled slot is re-issued rep_count times, each shifted by rep_interval.
module pulse_window_ch
  import pulses_pkg::*;
#(
  parameter int unsigned NUM_PULSE = 4,
  parameter int unsigned TW        = 32
) (
`ifdef PULSES_CPMG_EN
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           restart,
  input  logic [7:0]                     rep_count,
  input  logic [TW-1:0]                  rep_interval,
  input  logic [TW-1:0]                  period_eff,
`endif
  input  logic [TW-1:0]                  counter,
  input  logic [NUM_PULSE-1:0][TW-1:0]   start,
  input  logic [NUM_PULSE-1:0][TW-1:0]   stop,
  output logic                           win_c,
  output logic                           slot0_c
);

  logic [NUM_PULSE-1:0] en;
  logic [NUM_PULSE-1:0] hit;

  for (genvar p = 0; p < NUM_PULSE; p++) begin : g_slot
    assign en[p]  = start[p] < stop[p];
    assign hit[p] = en[p] && (counter >= start[p]) && (counter < stop[p]);
  end

  assign slot0_c = hit[0];

`ifdef PULSES_CPMG_EN
  localparam int unsigned TW1 = TW + 1;
  localparam int unsigned TW2 = TW + 2;

  // Priority chain: the highest-index enabled slot wins
  for (genvar p = 0; p < NUM_PULSE; p++) begin : g_last
    logic [TW-1:0] ls;
    logic [TW-1:0] le;
    logic          any;
    if (p == 0) begin : g_head
      assign ls  = start[0];
      assign le  = stop[0];
      assign any = en[0];
    end else begin : g_tail
      assign ls  = en[p] ? start[p] : g_last[p-1].ls;
      assign le  = en[p] ? stop[p]  : g_last[p-1].le;
      assign any = en[p] | g_last[p-1].any;
    end
  end

  logic [TW:0]    off;
  logic [7:0]     n_rep;
  logic [TW2-1:0] cstart_c;
  logic [TW2-1:0] cstop_c;
  logic           rep_hit_c;
  logic           advance_c;

  always_comb begin
    cstart_c  = TW2'(g_last[NUM_PULSE-1].ls) + TW2'(off);
    cstop_c   = TW2'(g_last[NUM_PULSE-1].le) + TW2'(off);
    rep_hit_c = g_last[NUM_PULSE-1].any && (n_rep != 8'd0) &&
                (cstart_c < TW2'(period_eff) - TW2'(1)) &&
                (TW2'(counter) >= cstart_c) && (TW2'(counter) < cstop_c);
    advance_c = g_last[NUM_PULSE-1].any && (n_rep < rep_count) &&
                (TW2'(counter) == cstop_c);
  end

  // Offset only advances when the counter reaches the copy's stop, so it stays below 2^TW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off   <= '0;
      n_rep <= '0;
    end else if (restart) begin
      off   <= '0;
      n_rep <= '0;
    end else if (advance_c) begin
      off   <= off + TW1'(rep_interval);
      n_rep <= n_rep + 8'd1;
    end
  end

  assign win_c = (|hit) | rep_hit_c;
`else
  assign win_c = |hit;
`endif

endmodule

// File: rtl/pulse_seq_multi.sv
// Multi-channel pulse sequencer with double-buffered timing registers.
// Optional PULSES_CPMG_EN builds per-channel slot repetition.
module pulse_seq_multi
  import pulses_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned NUM_PULSE = 4,
  parameter int unsigned TW        = 32,
  parameter int unsigned ATT_W     = 7,
  parameter int unsigned ATT_STEP  = 6,
  parameter int unsigned GUARD     = 20,
  parameter int unsigned AW        = addr_width(NUM_CH, NUM_PULSE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [TW-1:0]     cfg_wdata,
  input  logic              cfg_commit,
  input  logic              run,
  input  logic              cw_mode,
  input  logic [NUM_CH-1:0] cw_sel,
  input  logic [ATT_W-1:0]  pr_att,
  output logic              sync_on,
  output logic [NUM_CH-1:0] pulse_on,
  output logic [ATT_W-1:0]  pre_att,
  output logic              pre_block,
  output logic              cycle_start
);

  localparam int unsigned TW1      = TW + 1;
  localparam int unsigned AW1      = ATT_W + 1;
  localparam int unsigned REP_BASE = ADDR_SLOT_BASE + 2 * NUM_CH * NUM_PULSE;
`ifdef PULSES_CPMG_EN
  localparam int unsigned NREG     = REP_BASE + 2 * NUM_CH;
`else
  localparam int unsigned NREG     = REP_BASE;
`endif

  logic [TW-1:0]     sh_reg  [NREG];
  logic [TW-1:0]     act_reg [NREG];
  logic              pending;
  logic              run_q;
  logic [TW-1:0]     counter;

  logic [TW-1:0]     period_eff_c;
  logic              boundary_c;
  logic              take_c;
  logic              guard_c;
  logic [AW1-1:0]    att_sum_c;
  logic [ATT_W-1:0]  att_hi_c;
  logic [NUM_CH-1:0] win_c;
  logic [NUM_CH-1:0] slot0_c;

  always_comb begin
    period_eff_c = (act_reg[ADDR_PERIOD] < TW'(2)) ? TW'(2) : act_reg[ADDR_PERIOD];
    boundary_c   = run && (counter >= period_eff_c - TW'(1));
    // Swap at the boundary, while idle, or on the first running cycle
    take_c       = (pending || cfg_commit) && (boundary_c || !run || !run_q);
    guard_c      = (TW1'(counter) + TW1'(GUARD)) >= TW1'(period_eff_c);
    att_sum_c    = AW1'(pr_att) + AW1'(ATT_STEP);
    att_hi_c     = att_sum_c[ATT_W] ? {ATT_W{1'b1}} : att_sum_c[ATT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg  <= '{default: '0};
      act_reg <= '{default: '0};
      pending <= 1'b0;
    end else begin
      if (cfg_we && (32'(cfg_addr) < NREG)) sh_reg[cfg_addr] <= cfg_wdata;
      if (take_c) begin
        act_reg <= sh_reg;
        pending <= 1'b0;
      end else if (cfg_commit) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef PULSES_CPMG_EN
  logic restart_c;
  assign restart_c = !run || boundary_c;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_PULSE-1:0][TW-1:0] start_w;
    logic [NUM_PULSE-1:0][TW-1:0] stop_w;

    for (genvar p = 0; p < NUM_PULSE; p++) begin : g_p
      assign start_w[p] = act_reg[addr_slot(c, p, FLD_START, NUM_PULSE)];
      assign stop_w[p]  = act_reg[addr_slot(c, p, FLD_STOP, NUM_PULSE)];
    end

    pulse_window_ch #(
      .NUM_PULSE(NUM_PULSE),
      .TW       (TW)
    ) u_win (
`ifdef PULSES_CPMG_EN
      .clk         (clk),
      .rst         (rst),
      .restart     (restart_c),
      .rep_count   (act_reg[REP_BASE + 2 * c][7:0]),
      .rep_interval(act_reg[REP_BASE + 2 * c + 1]),
      .period_eff  (period_eff_c),
`endif
      .counter     (counter),
      .start       (start_w),
      .stop        (stop_w),
      .win_c       (win_c[c]),
      .slot0_c     (slot0_c[c])
    );
  end

  // Period counter and registered pin drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter     <= '0;
      run_q       <= 1'b0;
      sync_on     <= 1'b0;
      pulse_on    <= '0;
      pre_att     <= '0;
      pre_block   <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      run_q   <= run;
      counter <= (!run || boundary_c) ? '0 : counter + TW'(1);
      if (!run) begin
        sync_on     <= 1'b0;
        pulse_on    <= '0;
        pre_att     <= pr_att;
        pre_block   <= 1'b0;
        cycle_start <= 1'b0;
      end else begin
        cycle_start <= (counter == '0);
        sync_on     <= counter < act_reg[ADDR_SYNC];
        if (cw_mode) begin
          pulse_on  <= cw_sel;
          pre_block <= 1'b1;
          pre_att   <= pr_att;
        end else begin
          pulse_on  <= win_c;
          pre_block <= |pulse_on;
          pre_att   <= (guard_c || (|slot0_c)) ? att_hi_c : pr_att;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_seq_multi.sv
// Directed bench for pulse_seq_multi; PULSES_CPMG_EN adds the repeat checks.
module tb_pulse_seq_multi;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic       cfg_commit;
  logic       run;
  logic       cw_mode;
  logic [1:0] cw_sel;
  logic [6:0] pr_att;
  logic       sync_on;
  logic [1:0] pulse_on;
  logic [6:0] pre_att;
  logic       pre_block;
  logic       cycle_start;

  int nvec = 0;
  int nerr = 0;

  pulse_seq_multi dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .run        (run),
    .cw_mode    (cw_mode),
    .cw_sel     (cw_sel),
    .pr_att     (pr_att),
    .sync_on    (sync_on),
    .pulse_on   (pulse_on),
    .pre_att    (pre_att),
    .pre_block  (pre_block),
    .cycle_start(cycle_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k = counter value the sampled outputs were computed from
  typedef struct {
    int          k;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [11:0] mk(logic [1:0] p, logic s, logic [6:0] a, logic b, logic cs);
    return {p, s, a, b, cs};
  endfunction

  function automatic logic [11:0] obs();
    return {pulse_on, sync_on, pre_att, pre_block, cycle_start};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_cs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cycle_start && n < 1000);
  endtask

`ifdef PULSES_CPMG_EN
  task automatic count_ch1(output int hits, output logic at700, output logic at900);
    hits = 0; at700 = 1'b0; at900 = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (pulse_on[1]) hits++;
      if (k == 700) at700 = pulse_on[1];
      if (k == 900) at900 = pulse_on[1];
    end
  endtask
`endif

  vec_t tv[14];

  initial begin
    int n;
`ifdef PULSES_CPMG_EN
    int   hits;
    logic a7;
    logic a9;
`endif
    // period 100, ch0 [0,10) and [30,50), sync_stop 50, pr_att 20 -> 26 when raised
    tv[0]  = '{0,   mk(2'b01, 1, 7'd26, 0, 1)};
    tv[1]  = '{1,   mk(2'b01, 1, 7'd26, 1, 0)};
    tv[2]  = '{9,   mk(2'b01, 1, 7'd26, 1, 0)};
    tv[3]  = '{10,  mk(2'b00, 1, 7'd20, 1, 0)};
    tv[4]  = '{11,  mk(2'b00, 1, 7'd20, 0, 0)};
    tv[5]  = '{29,  mk(2'b00, 1, 7'd20, 0, 0)};
    tv[6]  = '{30,  mk(2'b01, 1, 7'd20, 0, 0)};
    tv[7]  = '{31,  mk(2'b01, 1, 7'd20, 1, 0)};
    tv[8]  = '{49,  mk(2'b01, 1, 7'd20, 1, 0)};
    tv[9]  = '{50,  mk(2'b00, 0, 7'd20, 1, 0)};
    tv[10] = '{79,  mk(2'b00, 0, 7'd20, 0, 0)};
    tv[11] = '{80,  mk(2'b00, 0, 7'd26, 0, 0)};
    tv[12] = '{99,  mk(2'b00, 0, 7'd26, 0, 0)};
    tv[13] = '{100, mk(2'b01, 1, 7'd26, 0, 1)};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    run = 1'b0; cw_mode = 1'b0; cw_sel = 2'b00; pr_att = 7'd20;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs()), 32'(mk(2'b00, 0, 7'd0, 0, 0)));
    rst = 1'b0;

    wr(5'd0, 32'd100);
    wr(5'd1, 32'd50);
    wr(5'd2, 32'd0);
    wr(5'd3, 32'd10);
    wr(5'd4, 32'd30);
    wr(5'd5, 32'd50);
    commit();

    run = 1'b1;
    for (int t = 0; t <= 100; t++) begin
      step();
      foreach (tv[i])
        if (tv[i].k == t) chk($sformatf("p100_k%0d", t), 32'(obs()), 32'(tv[i].exp));
    end

    // New period committed mid-period applies only from the next boundary
    wr(5'd0, 32'd200);
    commit();
    wait_cs(n);
    chk("old_period_tail", 32'(n), 32'd98);
    wait_cs(n);
    chk("new_period_len", 32'(n), 32'd200);

    pr_att = 7'd125;
    step();
    chk("att_saturate", 32'(pre_att), 32'd127);
    repeat (11) step();
    chk("att_base_125", 32'(pre_att), 32'd125);

    pr_att = 7'd20; cw_mode = 1'b1; cw_sel = 2'b10;
    step();
    chk("cw_k13", 32'(obs()), 32'(mk(2'b10, 1, 7'd20, 1, 0)));
    wait_cs(n);
    chk("cw_period", 32'(n), 32'd187);
    chk("cw_k0", 32'(obs()), 32'(mk(2'b10, 1, 7'd20, 1, 1)));

    cw_mode = 1'b0; run = 1'b0;
    step();
    chk("idle", 32'(obs()), 32'(mk(2'b00, 0, 7'd20, 0, 0)));
    wr(5'd1, 32'd10);
    commit();
    run = 1'b1;
    step();
    chk("restart_k0", 32'(obs()), 32'(mk(2'b01, 1, 7'd26, 0, 1)));
    repeat (9) step();
    chk("idle_swap_sync_k9", 32'(sync_on), 32'd1);
    step();
    chk("idle_swap_sync_k10", 32'(sync_on), 32'd0);

    // Asynchronous reset mid-run clears outputs immediately and empties the banks
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(obs()), 32'(mk(2'b00, 0, 7'd0, 0, 0)));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_banks_k0", 32'(obs()), 32'(mk(2'b00, 0, 7'd26, 0, 1)));
    wait_cs(n);
    chk("rst_min_period", 32'(n), 32'd2);

`ifdef PULSES_CPMG_EN
    run = 1'b0;
    step();
    wr(5'd0, 32'd1000);
    wr(5'd10, 32'd100);
    wr(5'd11, 32'd110);
    wr(5'd20, 32'd3);
    wr(5'd21, 32'd200);
    commit();
    run = 1'b1;
    count_ch1(hits, a7, a9);
    chk("rep3_hits", 32'(hits), 32'd40);
    chk("rep3_k700", 32'(a7), 32'd1);
    chk("rep3_k900", 32'(a9), 32'd0);

    run = 1'b0;
    step();
    wr(5'd20, 32'd5);
    commit();
    run = 1'b1;
    count_ch1(hits, a7, a9);
    chk("rep5_hits", 32'(hits), 32'd50);
    chk("rep5_k900", 32'(a9), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
